// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
// Word-bus bundle between the MEM-stage data-memory responder and the data
// SRAM / bus bridge. One transaction is held on the bus from request to ack.
//
// Signals:
//   bus_req    request, held high until bus_ack
//   bus_we     1 = write, 0 = read
//   bus_be     byte enables, bit k covers bus_wdata[8k+7:8k]
//   bus_addr   word address (byte address bits [AW+1:2])
//   bus_wdata  write data, already lane-steered
//   bus_ack    transaction done; bus_rdata valid in the same cycle
//   bus_rdata  read data word
//
// Modports: master (responder side), slave (memory side).
// ---------------------------------------------------------------------------
interface dmem_responder_if #(
    parameter int AW = 30
);
    logic          bus_req;
    logic          bus_we;
    logic [3:0]    bus_be;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_wdata;
    logic          bus_ack;
    logic [31:0]   bus_rdata;

    modport master (
        output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// MEM-stage data-memory responder. Turns each aligned MEM-stage load/store
// into exactly one req/ack word-bus transaction, steers store bytes onto the
// proper lanes, extends load data, flags misaligned addresses and raises the
// stall request while a transaction is outstanding.
//
// Optional feature: define DMEM_LLSC_EN to enable the LL/SC link. Without it
// llsc only makes a store report success (SC behaves as SW).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_read, mem_write        load / store in MEM (write wins if both)
//   mem_half, mem_byte         access size (byte wins over half)
//   mem_sign_ext               sign-extend load data
//   llsc                       LL (with mem_read) or SC (with mem_write)
//   addr, wdata                effective byte address, store data
//   stall, flush               global pipeline stall, CP0 flush
//   read_data                  formatted load data or SC status
//   stall_ctrl                 stall request to the hazard unit
//   adel, ades                 load / store address error (IDLE only)
//   bus                        word bus, master side
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int AW = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             mem_half,
    input  logic             mem_byte,
    input  logic             mem_sign_ext,
    input  logic             llsc,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic             stall,
    input  logic             flush,
    output logic [31:0]      read_data,
    output logic             stall_ctrl,
    output logic             adel,
    output logic             ades,
    dmem_responder_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state;
    state_e nextState;

    // ---------------- access decode ----------------
    logic isAccess;
    logic isSc;
    logic forceWord;
    logic accByte;
    logic accHalf;
    logic misaligned;
    logic scFail;
    logic startAccess;

    assign isAccess = mem_read | mem_write;
    assign isSc     = mem_write & llsc;

`ifdef DMEM_LLSC_EN
    logic        isLl;
    logic        link;
    logic [29:0] linkAddr;

    assign isLl      = mem_read & ~mem_write & llsc;
    assign forceWord = isLl | isSc;
    // An SC without a live link to the same word completes without the bus.
    assign scFail    = isSc & ~(link & (linkAddr == addr[31:2]));
`else
    // SC is a plain word store that always reports success.
    assign forceWord = isSc;
    assign scFail    = 1'b0;
`endif

    assign accByte    = mem_byte & ~forceWord;
    assign accHalf    = mem_half & ~mem_byte & ~forceWord;
    assign misaligned = accHalf ? addr[0] : (~accByte & (addr[1:0] != 2'b00));

    assign startAccess = (state == IDLE) & isAccess & ~misaligned & ~flush;

    // ---------------- store steering ----------------
    logic [3:0]  beNext;
    logic [31:0] wdataNext;

    always_comb begin
        // NOTE: defaults come first so every path assigns and no latch is inferred.
        beNext    = 4'b1111;
        wdataNext = wdata;
        if (mem_write) begin
            if (accByte) begin
                beNext    = 4'b0001 << addr[1:0];
                wdataNext = {4{wdata[7:0]}};
            end else if (accHalf) begin
                beNext    = addr[1] ? 4'b1100 : 4'b0011;
                wdataNext = {2{wdata[15:0]}};
            end
        end
    end

    // ---------------- latched transaction ----------------
    logic [AW-1:0] addrQ;
    logic          weQ;
    logic [3:0]    beQ;
    logic [31:0]   wdataQ;
    logic [1:0]    offQ;
    logic          byteQ;
    logic          halfQ;
    logic          sextQ;
    logic          scQ;
    logic          flushedQ;
    logic          flushNow;

    // A flush seen at any point of BUSY turns the completion into a drop.
    assign flushNow = flush | flushedQ;

    function automatic logic [31:0] formatLoad(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic        isByte,
        input logic        isHalf,
        input logic        sext
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        if (isByte)      return {{24{sext & b[7]}}, b};
        else if (isHalf) return {{16{sext & h[15]}}, h};
        else             return word;
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (startAccess) nextState = scFail ? DONE : BUSY;
            BUSY: if (bus.bus_ack) nextState = flushNow ? IDLE : DONE;
            DONE: if (!stall)      nextState = IDLE;
            default:               nextState = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        stall_ctrl  = 1'b0;
        bus.bus_req = 1'b0;
        case (state)
            IDLE:    stall_ctrl = startAccess;
            BUSY: begin
                stall_ctrl  = 1'b1;
                bus.bus_req = 1'b1;
            end
            default: ;
        endcase
        adel = (state == IDLE) & isAccess & ~mem_write & misaligned;
        ades = (state == IDLE) & mem_write & misaligned;
    end

    assign bus.bus_we    = weQ;
    assign bus.bus_be    = beQ;
    assign bus.bus_addr  = addrQ;
    assign bus.bus_wdata = wdataQ;

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrQ     <= '0;
            weQ       <= 1'b0;
            beQ       <= 4'b0000;
            wdataQ    <= 32'd0;
            offQ      <= 2'd0;
            byteQ     <= 1'b0;
            halfQ     <= 1'b0;
            sextQ     <= 1'b0;
            scQ       <= 1'b0;
            flushedQ  <= 1'b0;
            read_data <= 32'd0;
        end else begin
            if (startAccess && !scFail) begin
                addrQ  <= addr[AW+1:2];
                weQ    <= mem_write;
                beQ    <= beNext;
                wdataQ <= wdataNext;
                offQ   <= addr[1:0];
                byteQ  <= accByte;
                halfQ  <= accHalf;
                sextQ  <= mem_sign_ext;
                scQ    <= isSc;
            end

            if (state == BUSY) flushedQ <= (flushedQ | flush) & ~bus.bus_ack;
            else               flushedQ <= 1'b0;

            if (startAccess && scFail) begin
                read_data <= 32'd0;
            end else if ((state == BUSY) && bus.bus_ack && !flushNow) begin
                if (!weQ)     read_data <= formatLoad(bus.bus_rdata, offQ, byteQ, halfQ, sextQ);
                else if (scQ) read_data <= 32'd1;
            end
        end
    end

`ifdef DMEM_LLSC_EN
    // ---------------- LL/SC link ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link     <= 1'b0;
            linkAddr <= 30'd0;
        end else if (flush) begin
            link <= 1'b0;
        end else if ((state == IDLE) && isSc) begin
            link <= 1'b0;
        end else if (startAccess && isLl) begin
            link     <= 1'b1;
            linkAddr <= addr[31:2];
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder. A small transaction-level model derives
// bus beats, load results, SC status and stall length from plain arithmetic
// on address, size and data; a negedge process plays the memory side and
// compares every bus beat against the expected one.
// ---------------------------------------------------------------------------
module tb_dmem_responder;
    localparam int AW = 30;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, mem_half, mem_byte, mem_sign_ext, llsc;
    logic [31:0] addr, wdata;
    logic        stall, flush;
    logic [31:0] read_data;
    logic        stall_ctrl, adel, ades;

    dmem_responder_if #(.AW(AW)) bus ();

    dmem_responder #(.AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_half     (mem_half),
        .mem_byte     (mem_byte),
        .mem_sign_ext (mem_sign_ext),
        .llsc         (llsc),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .flush        (flush),
        .read_data    (read_data),
        .stall_ctrl   (stall_ctrl),
        .adel         (adel),
        .ades         (ades),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- expected bus beat ----------------
    logic        beatArmed = 1'b0;
    logic [31:0] expWe, expBe, expAddr, expWdata;
    int          ackLat  = 0;
    int          waitCnt = 0;
    int          beatCnt = 0;
    logic [31:0] lastBe, lastWdata, lastAddr;

    // ---------------- model state ----------------
    logic [31:0] mRd       = 32'd0;
    logic        mLink     = 1'b0;
    logic [29:0] mLinkAddr = 30'd0;

    function automatic logic [31:0] modelBe(input logic [31:0] a, input int sz);
        if (sz == 4) return 32'hF;
        return ((32'd1 << sz) - 32'd1) << (a % 4);
    endfunction

    function automatic logic [31:0] modelWdata(input logic [31:0] wd, input int sz);
        if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] rd, input logic [31:0] a,
                                              input int sz, input bit sx);
        logic [31:0] v, mask;
        v = rd >> (8 * (a % 4));
        if (sz == 4) return v;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v = v & mask;
        if (sx && (v > (mask >> 1))) v = v | ~mask;
        return v;
    endfunction

    // Memory side and per-cycle beat comparison.
    always @(negedge clk) begin
        if (!beatArmed) check("no_req", 32'(bus.bus_req), 32'd0);
        if (bus.bus_req) begin
            if (beatArmed) begin
                check("bus_we",   32'(bus.bus_we),   expWe);
                check("bus_be",   32'(bus.bus_be),   expBe);
                check("bus_addr", 32'(bus.bus_addr), expAddr);
                if (expWe[0]) check("bus_wdata", bus.bus_wdata, expWdata);
            end
            if (waitCnt == ackLat) begin
                bus.bus_ack = 1'b1;
                beatCnt++;
                lastBe    = 32'(bus.bus_be);
                lastWdata = bus.bus_wdata;
                lastAddr  = 32'(bus.bus_addr);
            end else begin
                bus.bus_ack = 1'b0;
            end
            waitCnt++;
        end else begin
            bus.bus_ack = 1'b0;
            waitCnt     = 0;
        end
    end

    // flushMode: 0 none, 1 flush held from the IDLE cycle, 2 flush raised in BUSY.
    task automatic op(input string name, input bit isStore, input int sz, input bit sx,
                      input bit ll, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input int lat, input int hold,
                      input int flushMode, output int stallCnt);
        bit          aligned, scFailExp, issue, timedOut;
        int          expStall;
        logic [31:0] expRd;

        aligned   = (a % sz) == 0;
        scFailExp = 1'b0;
`ifdef DMEM_LLSC_EN
        if (ll && isStore) scFailExp = !(mLink && (mLinkAddr == a[31:2]));
`endif
        issue = aligned && (flushMode != 1);
        expRd = mRd;
        if (issue && scFailExp)               expRd = 32'd0;
        else if (issue && flushMode != 2) begin
            if (!isStore) expRd = modelLoad(rd, a, sz, sx);
            else if (ll)  expRd = 32'd1;
        end
        expStall = !issue ? 0 : (scFailExp ? 1 : lat + 2);

        expWe    = 32'(isStore);
        expBe    = isStore ? modelBe(a, sz) : 32'hF;
        expAddr  = a >> 2;
        expWdata = modelWdata(wd, sz);
        ackLat   = lat;
        beatCnt  = 0;

        @(posedge clk); #1;
        beatArmed     = issue && !scFailExp;
        mem_read      = !isStore;
        mem_write     = isStore;
        mem_byte      = (sz == 1);
        mem_half      = (sz == 2);
        mem_sign_ext  = sx;
        llsc          = ll;
        addr          = a;
        wdata         = wd;
        bus.bus_rdata = rd;
        flush         = (flushMode == 1);
        stall         = 1'b0;

        stallCnt = 0;
        timedOut = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check({name, "_adel"}, 32'(adel), 32'(!aligned && !isStore));
                check({name, "_ades"}, 32'(ades), 32'(!aligned && isStore));
            end else begin
                check({name, "_adel_mask"}, 32'(adel), 32'd0);
                check({name, "_ades_mask"}, 32'(ades), 32'd0);
            end
            if (!stall_ctrl) begin
                timedOut = 1'b0;
                break;
            end
            stallCnt++;
            if (k == 1 && flushMode == 2) flush = 1'b1;
        end
        check({name, "_timeout"}, 32'(timedOut), 32'd0);
        check({name, "_stall"}, stallCnt, expStall);
        check({name, "_rdata"}, read_data, expRd);

        stall = (hold > 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check({name, "_hold"}, 32'(stall_ctrl), 32'd0);
        end
        stall = 1'b0;

        @(posedge clk); #1;
        mem_read = 0; mem_write = 0; mem_byte = 0; mem_half = 0;
        mem_sign_ext = 0; llsc = 0; addr = 0; wdata = 0; flush = 0;
        @(negedge clk);
        check({name, "_beats"}, beatCnt, (issue && !scFailExp) ? 32'd1 : 32'd0);
        beatArmed = 1'b0;

        mRd = expRd;
        if (flushMode != 0) mLink = 1'b0;
        else if (aligned && ll && isStore) mLink = 1'b0;
        else if (aligned && ll && !isStore) begin
            mLink     = 1'b1;
            mLinkAddr = a[31:2];
        end
    endtask

    int sc;

    initial begin
        rst_n = 0; mem_read = 0; mem_write = 0; mem_half = 0; mem_byte = 0;
        mem_sign_ext = 0; llsc = 0; addr = 0; wdata = 0; stall = 0; flush = 0;
        bus.bus_rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall_ctrl", 32'(stall_ctrl),    32'd0);
        check("rst_bus_req",    32'(bus.bus_req),   32'd0);
        check("rst_bus_we",     32'(bus.bus_we),    32'd0);
        check("rst_bus_be",     32'(bus.bus_be),    32'd0);
        check("rst_bus_addr",   32'(bus.bus_addr),  32'd0);
        check("rst_bus_wdata",  bus.bus_wdata,      32'd0);
        check("rst_read_data",  read_data,          32'd0);
        @(posedge clk); #1 rst_n = 1;

        //  name        st sz sx ll addr          wdata         rdata        lat hold fl
        op("lb_s",      0, 1, 1, 0, 32'h0000_0102, 32'h0,        32'h1280_3456, 0, 0, 0, sc);
        check("pin_lb_s", read_data, 32'hFFFF_FF80);
        op("lbu",       0, 1, 0, 0, 32'h0000_0102, 32'h0,        32'h1280_3456, 0, 0, 0, sc);
        check("pin_lbu", read_data, 32'h0000_0080);
        op("lh_s",      0, 2, 1, 0, 32'h0000_0106, 32'h0,        32'h8001_7FFF, 1, 0, 0, sc);
        op("lhu",       0, 2, 0, 0, 32'h0000_0104, 32'h0,        32'h8001_F00D, 0, 0, 0, sc);
        op("lw",        0, 4, 0, 0, 32'h0000_0108, 32'h0,        32'hDEAD_BEEF, 0, 0, 0, sc);
        op("sh",        1, 2, 0, 0, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0,        0, 0, 0, sc);
        check("pin_sh_be",    lastBe,    32'h0000_000C);
        check("pin_sh_wdata", lastWdata, 32'hBEEF_BEEF);
        check("pin_sh_addr",  lastAddr,  32'h0000_0080);
        op("sb",        1, 1, 0, 0, 32'h0000_0203, 32'h1234_56A5, 32'h0,        1, 0, 0, sc);
        op("sw",        1, 4, 0, 0, 32'h0000_0204, 32'hCAFE_F00D, 32'h0,        0, 0, 0, sc);
        op("lw_mis",    0, 4, 0, 0, 32'h0000_0301, 32'h0,        32'h5555_5555, 0, 0, 0, sc);
        check("pin_mis_stall", sc, 32'd0);
        op("sh_mis",    1, 2, 0, 0, 32'h0000_0305, 32'h1111_2222, 32'h0,        0, 0, 0, sc);
        op("lw_wait",   0, 4, 0, 0, 32'h0000_0600, 32'h0,        32'h0BAD_F00D, 3, 2, 0, sc);
        check("pin_wait_stall", sc, 32'd5);
        op("lw_flbusy", 0, 4, 0, 0, 32'h0000_0700, 32'h0,        32'h7777_7777, 1, 0, 2, sc);
        op("lw_flidle", 0, 4, 0, 0, 32'h0000_0704, 32'h0,        32'h6666_6666, 0, 0, 1, sc);

`ifdef DMEM_LLSC_EN
        op("ll",        0, 4, 0, 1, 32'h0000_0400, 32'h0,        32'h0000_1234, 0, 0, 0, sc);
        op("sc_ok",     1, 4, 0, 1, 32'h0000_0400, 32'h1122_3344, 32'h0,        0, 0, 0, sc);
        check("pin_sc_ok", read_data, 32'd1);
        op("sc_again",  1, 4, 0, 1, 32'h0000_0400, 32'h5566_7788, 32'h0,        0, 0, 0, sc);
        check("pin_sc_again", read_data, 32'd0);
        op("ll2",       0, 4, 0, 1, 32'h0000_0400, 32'h0,        32'h0000_4321, 0, 0, 0, sc);
        op("sc_ok2",    1, 4, 0, 1, 32'h0000_0400, 32'h99AA_BBCC, 32'h0,        1, 0, 0, sc);
        op("ll3",       0, 4, 0, 1, 32'h0000_0400, 32'h0,        32'h0000_5678, 0, 0, 0, sc);
        op("flush",     0, 4, 0, 0, 32'h0000_0408, 32'h0,        32'h0,         0, 0, 1, sc);
        op("sc_flushed",1, 4, 0, 1, 32'h0000_0400, 32'hDDDD_EEEE, 32'h0,        0, 0, 0, sc);
        check("pin_sc_flushed", read_data, 32'd0);
        op("ll4",       0, 4, 0, 1, 32'h0000_0400, 32'h0,        32'h0000_9ABC, 0, 0, 0, sc);
        op("sc_wrong",  1, 4, 0, 1, 32'h0000_0404, 32'hFFFF_0000, 32'h0,        0, 0, 0, sc);
`else
        op("sc_as_sw",  1, 4, 0, 1, 32'h0000_0400, 32'h1122_3344, 32'h0,        0, 0, 0, sc);
        check("pin_sc_as_sw", read_data, 32'd1);
`endif

        // Reset in the middle of a BUSY load.
        expWe = 32'd0; expBe = 32'hF; expAddr = 32'h0000_0500 >> 2; ackLat = 50;
        @(posedge clk); #1;
        beatArmed = 1'b1;
        mem_read = 1; addr = 32'h0000_0500; bus.bus_rdata = 32'h3C3C_3C3C;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy_req", 32'(bus.bus_req), 32'd1);
        #2 rst_n = 0;
        #1;
        check("rst_async_req",  32'(bus.bus_req), 32'd0);
        check("rst_async_data", read_data,        32'd0);
        mem_read = 0; addr = 0;
        mRd = 32'd0; mLink = 1'b0;
        @(posedge clk); #1;
        beatArmed = 1'b0;
        rst_n = 1;

        op("lw_after_rst", 0, 4, 0, 0, 32'h0000_0800, 32'h0, 32'hA5A5_5A5A, 0, 0, 0, sc);
        check("pin_after_rst", read_data, 32'hA5A5_5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
